// File: rtl/cb_param_pkg.sv
// ============================================================================
// Module   : cb_param_pkg
// Brief    : Shared sizing functions, loader state encoding and frame index helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package cb_param_pkg;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_SHIFT  = 2'd1,
        LD_COMMIT = 2'd2,
        LD_ERROR  = 2'd3
    } ld_state_t;

    function automatic int sel_w(input int n_in, input int w);
        return $clog2(n_in * w + 1);
    endfunction

    function automatic int cfg_bits(input int n_in, input int n_out, input int w);
        return n_out * w * sel_w(n_in, w) + n_out;
    endfunction

    // LSB of the select field that drives flattened output bit j
    function automatic int sel_lsb(input int j, input int sw);
        return j * sw;
    endfunction

    function automatic int reg_idx(input int p, input int n_out, input int w, input int sw);
        return n_out * w * sw + p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cb_param_loader_if.sv
// ============================================================================
// Module   : cb_param_loader_if
// Brief    : Configuration chain, status and routing buses of the connection box
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cb_param_loader_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int W     = 4
);
    logic                 prog_en;
    logic                 prog_in;
    logic                 prog_out;
    logic [N_IN*W-1:0]    in_bus;
    logic [N_OUT*W-1:0]   out_bus;
    logic                 cfg_valid;
    logic                 cfg_err;
    logic                 cfg_busy;

    modport master (
        output prog_en, prog_in, in_bus,
        input  prog_out, out_bus, cfg_valid, cfg_err, cfg_busy
    );

    modport slave (
        input  prog_en, prog_in, in_bus,
        output prog_out, out_bus, cfg_valid, cfg_err, cfg_busy
    );
endinterface

`default_nettype wire

// File: rtl/cb_cfg_loader.sv
// ============================================================================
// Module   : cb_cfg_loader
// Brief    : Double-buffered serial frame loader with exact-length atomic commit
// Revision : 1.0
// ============================================================================
`default_nettype none

module cb_cfg_loader
    import cb_param_pkg::*;
#(
    parameter  int N_IN       = 4,
    parameter  int N_OUT      = 4,
    parameter  int W          = 4,
    localparam int c_CFG_BITS = cfg_bits(N_IN, N_OUT, W)
) (
    input  logic                  clb_clk,
    input  logic                  rst_n,
    input  logic                  prog_en,
    input  logic                  prog_in,
    output logic                  prog_out,
    output logic                  cfg_valid,
    output logic                  cfg_err,
    output logic                  cfg_busy,
    output logic [c_CFG_BITS-1:0] active_cfg
);
    localparam int                 c_CNT_W    = $clog2(c_CFG_BITS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CFG_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_CFG_BITS + 1);

    ld_state_t               r_state;
    ld_state_t               w_next_state;
    logic [c_CFG_BITS-1:0]   r_shadow;
    logic [c_CFG_BITS-1:0]   r_active;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_prog_out;
    logic                    r_valid;
    logic                    r_err;
    logic                    w_start;
    logic                    w_shift;
    logic                    w_commit;
    logic                    w_error;
    logic                    w_busy;

    always_ff @(posedge clb_clk) begin
        if (!rst_n) r_state <= LD_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LD_IDLE:   if (prog_en) w_next_state = LD_SHIFT;
            LD_SHIFT:  if (!prog_en) w_next_state = (r_count == c_CNT_FULL) ? LD_COMMIT : LD_ERROR;
            LD_COMMIT: w_next_state = LD_IDLE;
            LD_ERROR:  w_next_state = LD_IDLE;
            default:   w_next_state = LD_IDLE;
        endcase
    end

    // prog_en is deliberately ignored in COMMIT/ERROR so a frame never straddles a commit
    always_comb begin
        w_start  = (r_state == LD_IDLE) && prog_en;
        w_shift  = prog_en && ((r_state == LD_IDLE) || (r_state == LD_SHIFT));
        w_commit = (r_state == LD_COMMIT);
        w_error  = (r_state == LD_ERROR);
        w_busy   = (r_state != LD_IDLE);
    end

    always_ff @(posedge clb_clk) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_count    <= '0;
            r_prog_out <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shadow   <= {prog_in, r_shadow[c_CFG_BITS-1:1]};
                r_prog_out <= r_shadow[0];
            end
            if (w_start) begin
                r_count <= c_CNT_W'(1);
                r_err   <= 1'b0;
            end else if (w_shift && (r_count != c_CNT_SAT)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_commit) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
            end
            if (w_error) r_err <= 1'b1;
        end
    end

    assign prog_out   = r_prog_out;
    assign cfg_valid  = r_valid;
    assign cfg_err    = r_err;
    assign cfg_busy   = w_busy;
    assign active_cfg = r_active;

endmodule

`default_nettype wire

// File: rtl/cb_param_loader.sv
// ============================================================================
// Module   : cb_param_loader
// Brief    : Bit-level connection box, optional per-channel output registers
// Revision : 1.0
// ============================================================================
`default_nettype none

module cb_param_loader
    import cb_param_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int W     = 4
) (
    input  logic              clb_clk,
    input  logic              rst_n,
    cb_param_loader_if.slave  bus
);
    localparam int c_SRC      = N_IN * W;
    localparam int c_SEL_W    = sel_w(N_IN, W);
    localparam int c_CFG_BITS = cfg_bits(N_IN, N_OUT, W);
    localparam int c_EXT      = 1 << c_SEL_W;

    logic [c_CFG_BITS-1:0] w_active;
    logic [c_EXT-1:0]      w_src_ext;
    logic [N_OUT*W-1:0]    w_mux;
    logic [N_OUT*W-1:0]    w_out;
    logic                  w_valid;

    // Zero-padding to the full select range makes out-of-range selects read 0
    assign w_src_ext = {{(c_EXT - c_SRC){1'b0}}, bus.in_bus};

    cb_cfg_loader #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .W     (W)
    ) u_loader (
        .clb_clk    (clb_clk),
        .rst_n      (rst_n),
        .prog_en    (bus.prog_en),
        .prog_in    (bus.prog_in),
        .prog_out   (bus.prog_out),
        .cfg_valid  (w_valid),
        .cfg_err    (bus.cfg_err),
        .cfg_busy   (bus.cfg_busy),
        .active_cfg (w_active)
    );

    generate
        for (genvar p = 0; p < N_OUT; p++) begin : g_chan
            logic [W-1:0] r_q;

            for (genvar b = 0; b < W; b++) begin : g_bit
                localparam int c_J = p * W + b;
                logic [c_SEL_W-1:0] w_sel;
                assign w_sel      = w_active[sel_lsb(c_J, c_SEL_W) +: c_SEL_W];
                assign w_mux[c_J] = w_src_ext[w_sel];
            end

            always_ff @(posedge clb_clk) begin
                if (!rst_n) r_q <= '0;
                else        r_q <= w_mux[p*W +: W];
            end

            assign w_out[p*W +: W] = !w_valid ? '0 :
                                     w_active[reg_idx(p, N_OUT, W, c_SEL_W)] ? r_q :
                                     w_mux[p*W +: W];
        end
    endgenerate

    assign bus.out_bus   = w_out;
    assign bus.cfg_valid = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_cb_param_loader.sv
// ============================================================================
// Module   : tb_cb_param_loader
// Brief    : Directed self-checking bench for the connection box loader
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cb_param_loader;
    logic clb_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [127:0] f_swap, f_ident, f_regc, f_null, cap;
    logic         err1;

    always #5 clb_clk = ~clb_clk;

    cb_param_loader_if #(.N_IN(4), .N_OUT(4), .W(4)) bus ();

    cb_param_loader #(.N_IN(4), .N_OUT(4), .W(4)) dut (
        .clb_clk (clb_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // src = -1 selects code 16 (no source) for every bit of the channel
    function automatic logic [127:0] mk_frame(input int s0, input int s1, input int s2,
                                              input int s3, input logic [3:0] regm);
        logic [127:0] f;
        int           src [4];
        int           sel;
        f   = '0;
        src = '{s0, s1, s2, s3};
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                sel = (src[p] < 0) ? 16 : src[p] * 4 + b;
                f[(p*4+b)*5 +: 5] = 5'(sel);
            end
            f[80+p] = regm[p];
        end
        return f;
    endfunction

    task automatic send_frame(input logic [127:0] f, input int n,
                              output logic [127:0] c, output logic e1);
        c  = '0;
        e1 = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.prog_en = 1'b1;
            bus.prog_in = f[i];
            @(negedge clb_clk);
            c[i] = bus.prog_out;
            if (i == 0) e1 = bus.cfg_err;
        end
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
    endtask

    task automatic test_reset;
        bus.in_bus = 16'h3914;
        repeat (3) @(negedge clb_clk);
        rst_n = 1'b1;
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0000", bus.out_bus); end
        n_checks++; if (bus.cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.cfg_valid); end
        n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.cfg_err); end
        n_checks++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.cfg_busy); end
        n_checks++; if (bus.prog_out !== 1'b0) begin n_fail++; $display("FAIL reset_prog_out: got %b want 0", bus.prog_out); end
    endtask

    task automatic test_swap;
        bus.in_bus = 16'h3914;
        send_frame(f_swap, 84, cap, err1);
        @(negedge clb_clk);
        n_checks++; if (bus.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL swap_busy_commit: got %b want 1", bus.cfg_busy); end
        n_checks++; if (bus.out_bus !== 16'h0) begin n_fail++; $display("FAIL swap_out_early: got %h want 0000", bus.out_bus); end
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h9341) begin n_fail++; $display("FAIL swap_out: got %h want 9341", bus.out_bus); end
        n_checks++; if (bus.cfg_valid !== 1'b1) begin n_fail++; $display("FAIL swap_valid: got %b want 1", bus.cfg_valid); end
        n_checks++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL swap_busy_idle: got %b want 0", bus.cfg_busy); end
        n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL swap_err: got %b want 0", bus.cfg_err); end
    endtask

    task automatic test_bad_length;
        repeat (2) @(negedge clb_clk);
        send_frame(f_ident, 83, cap, err1);
        @(negedge clb_clk);
        n_checks++; if (bus.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL short_busy_error: got %b want 1", bus.cfg_busy); end
        @(negedge clb_clk);
        n_checks++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b want 1", bus.cfg_err); end
        n_checks++; if (bus.cfg_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid: got %b want 1", bus.cfg_valid); end
        n_checks++; if (bus.out_bus !== 16'h9341) begin n_fail++; $display("FAIL short_out: got %h want 9341", bus.out_bus); end
        repeat (2) @(negedge clb_clk);
        send_frame(f_ident, 85, cap, err1);
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL long_err_clear: got %b want 0", err1); end
        repeat (2) @(negedge clb_clk);
        n_checks++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL long_err: got %b want 1", bus.cfg_err); end
        n_checks++; if (bus.out_bus !== 16'h9341) begin n_fail++; $display("FAIL long_out: got %h want 9341", bus.out_bus); end
    endtask

    task automatic test_recover;
        repeat (2) @(negedge clb_clk);
        send_frame(f_ident, 84, cap, err1);
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL recover_err_clear: got %b want 0", err1); end
        repeat (2) @(negedge clb_clk);
        n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL recover_err: got %b want 0", bus.cfg_err); end
        n_checks++; if (bus.out_bus !== 16'h3914) begin n_fail++; $display("FAIL recover_out: got %h want 3914", bus.out_bus); end
    endtask

    task automatic test_reg_channel;
        repeat (2) @(negedge clb_clk);
        send_frame(f_regc, 84, cap, err1);
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h3914) begin n_fail++; $display("FAIL regc_hold: got %h want 3914", bus.out_bus); end
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h9314) begin n_fail++; $display("FAIL regc_k1: got %h want 9314", bus.out_bus); end
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h9311) begin n_fail++; $display("FAIL regc_k2: got %h want 9311", bus.out_bus); end
        bus.in_bus = 16'h39E4;
        #1;
        n_checks++; if (bus.out_bus !== 16'h93E1) begin n_fail++; $display("FAIL regc_step_comb: got %h want 93e1", bus.out_bus); end
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h93EE) begin n_fail++; $display("FAIL regc_step_reg: got %h want 93ee", bus.out_bus); end
    endtask

    task automatic test_null_select;
        repeat (2) @(negedge clb_clk);
        send_frame(f_null, 84, cap, err1);
        repeat (3) @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h0) begin n_fail++; $display("FAIL null_out_a: got %h want 0000", bus.out_bus); end
        n_checks++; if (bus.cfg_valid !== 1'b1) begin n_fail++; $display("FAIL null_valid: got %b want 1", bus.cfg_valid); end
        bus.in_bus = 16'hFFFF;
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h0) begin n_fail++; $display("FAIL null_out_ffff: got %h want 0000", bus.out_bus); end
        bus.in_bus = 16'hA5A5;
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h0) begin n_fail++; $display("FAIL null_out_a5a5: got %h want 0000", bus.out_bus); end
    endtask

    task automatic test_reset_mid;
        repeat (2) @(negedge clb_clk);
        bus.in_bus = 16'h3914;
        send_frame(f_swap, 40, cap, err1);
        rst_n = 1'b0;
        @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h0) begin n_fail++; $display("FAIL rstmid_out: got %h want 0000", bus.out_bus); end
        n_checks++; if (bus.cfg_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus.cfg_valid); end
        n_checks++; if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.cfg_busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clb_clk);
        send_frame(f_ident, 84, cap, err1);
        n_checks++; if (cap[83:0] !== 84'h0) begin n_fail++; $display("FAIL rstmid_shadow_cleared: got %h want 0", cap[83:0]); end
        repeat (2) @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h3914) begin n_fail++; $display("FAIL rstmid_recommit: got %h want 3914", bus.out_bus); end
        n_checks++; if (bus.cfg_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_after: got %b want 1", bus.cfg_valid); end
    endtask

    task automatic test_chain;
        repeat (2) @(negedge clb_clk);
        send_frame(f_swap, 84, cap, err1);
        n_checks++; if (cap[83:0] !== f_ident[83:0]) begin n_fail++; $display("FAIL chain_ident: got %h want %h", cap[83:0], f_ident[83:0]); end
        repeat (2) @(negedge clb_clk);
        n_checks++; if (bus.out_bus !== 16'h9341) begin n_fail++; $display("FAIL chain_swap_out: got %h want 9341", bus.out_bus); end
        repeat (2) @(negedge clb_clk);
        send_frame(f_ident, 84, cap, err1);
        n_checks++; if (cap[83:0] !== f_swap[83:0]) begin n_fail++; $display("FAIL chain_swap: got %h want %h", cap[83:0], f_swap[83:0]); end
        repeat (2) @(negedge clb_clk);
    endtask

    initial begin
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        bus.in_bus  = '0;
        f_swap  = mk_frame(1, 0, 3, 2, 4'b0000);
        f_ident = mk_frame(0, 1, 2, 3, 4'b0000);
        f_regc  = mk_frame(1, 1, 3, 2, 4'b0001);
        f_null  = mk_frame(-1, -1, -1, -1, 4'b1010);
        test_reset();
        test_swap();
        test_bad_length();
        test_recover();
        test_reg_channel();
        test_null_select();
        test_reset_mid();
        test_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
